// File: rtl/fabric_ctrl.sv
// Sequencer for the shortest-path node fabric: loads packed weights over the bus,
// runs the array from a seeded start node until it settles, then packs direction codes back out.
module fabric_ctrl #(
  parameter int          DIM      = 32,
  parameter int          WW       = 4,
  parameter int          DW       = 3,
  parameter logic [31:0] ADDR_MAP = 32'h40000000,
  parameter logic [31:0] ADDR_DIR = 32'h40002000,
  parameter int          SETTLE   = 16,
  localparam int         N        = DIM * DIM,
  localparam int         CW       = $clog2(DIM),
  localparam int         IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          ctrl_wr,
  input  logic [31:0]   ctrl_in,
  output logic [31:0]   ctrl_out,
  output logic          txn_req,
  output logic          txn_wr,
  output logic [31:0]   txn_addr,
  output logic [31:0]   txn_wdata,
  input  logic          txn_rdy,
  input  logic [31:0]   txn_rdata,
  output logic          fab_rst,
  output logic          fab_ld,
  output logic [IW-1:0] fab_ld_idx,
  output logic [WW-1:0] fab_ld_weight,
  output logic          fab_src_vld,
  output logic [IW-1:0] fab_src_idx,
  input  logic          fab_activity,
  output logic [IW-1:0] fab_rd_idx,
  input  logic [DW-1:0] fab_rd_dir,
  output logic          int_done
);

  localparam int          WPW  = 32 / WW;
  localparam int          CNTW = $clog2(SETTLE + 1);
  localparam logic [IW:0] N_L  = (IW+1)'(N);
  localparam logic [IW:0] NM1  = (IW+1)'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_UNPACK, S_RUN_INIT, S_RUN, S_PK_GATHER, S_PK_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            run_q, run_d, load_q, load_d, done_q, done_d, ie_q, ie_d;
  logic            abort_q, abort_d;
  logic [4:0]      sy_q, sy_d, sx_q, sx_d;
  logic [IW:0]     node_q, node_d, word_q, word_d;
  logic [2:0]      slot_q, slot_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [31:0]     data_q, data_d;

  logic            busy, req_now, abort_now;
  logic [31:0]     ld_slot;
  logic            unused_ok;

  assign unused_ok   = ^ctrl_in[27:10];
  assign ctrl_out    = {run_q, load_q, done_q, ie_q, 18'd0, sy_q, sx_q};
  assign fab_src_idx = {sy_q[CW-1:0], sx_q[CW-1:0]};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      abort_q <= 1'b0;
      sy_q    <= '0;
      sx_q    <= '0;
      node_q  <= '0;
      word_q  <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      load_q  <= load_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
      abort_q <= abort_d;
      sy_q    <= sy_d;
      sx_q    <= sx_d;
      node_q  <= node_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    load_d  = load_q;
    done_d  = done_q;
    ie_d    = ie_q;
    abort_d = abort_q;
    sy_d    = sy_q;
    sx_d    = sx_q;
    node_d  = node_q;
    word_d  = word_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    fab_rst       = 1'b0;
    fab_ld        = 1'b0;
    fab_ld_idx    = '0;
    fab_ld_weight = '0;
    fab_src_vld   = 1'b0;
    fab_rd_idx    = '0;
    int_done      = 1'b0;

    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    req_now   = (state_q == S_LD_REQ) || (state_q == S_PK_WRITE);
    abort_now = ctrl_wr && busy && !ctrl_in[31] && !ctrl_in[30];
    ld_slot   = 32'(node_q) & 32'(WPW - 1);

    txn_req   = req_now;
    txn_wr    = (state_q == S_PK_WRITE);
    txn_addr  = '0;
    txn_wdata = '0;
    if (state_q == S_LD_REQ)   txn_addr = ADDR_MAP + (32'(word_q) << 2);
    if (state_q == S_PK_WRITE) begin
      txn_addr  = ADDR_DIR + (32'(word_q) << 2);
      txn_wdata = data_q;
    end

    if (ctrl_wr && !busy) begin
      run_d  = ctrl_in[31];
      load_d = ctrl_in[30];
      ie_d   = ctrl_in[28];
      sy_d   = ctrl_in[9:5];
      sx_d   = ctrl_in[4:0];
      if (ctrl_in[29]) done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (load_q) begin
          state_d = S_LD_REQ;
          node_d  = '0;
          word_d  = '0;
        end else if (run_q) begin
          state_d = S_RUN_INIT;
        end
      end
      S_LD_REQ: begin
        if (txn_rdy) begin
          data_d  = txn_rdata;
          state_d = S_LD_UNPACK;
        end
      end
      S_LD_UNPACK: begin
        fab_ld        = 1'b1;
        fab_ld_idx    = node_q[IW-1:0];
        fab_ld_weight = data_q[ld_slot*WW +: WW];
        node_d        = node_q + (IW+1)'(1);
        if (node_q == NM1) begin
          load_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ld_slot == 32'(WPW - 1)) begin
          word_d  = word_q + (IW+1)'(1);
          state_d = S_LD_REQ;
        end
      end
      S_RUN_INIT: begin
        fab_rst     = 1'b1;
        fab_src_vld = 1'b1;
        cnt_d       = CNTW'(SETTLE);
        state_d     = S_RUN;
      end
      S_RUN: begin
        fab_src_vld = 1'b1;
        if (fab_activity) begin
          cnt_d = CNTW'(SETTLE);
        end else if (cnt_q == CNTW'(1)) begin
          cnt_d   = '0;
          node_d  = '0;
          word_d  = '0;
          slot_d  = '0;
          data_d  = '0;
          state_d = S_PK_GATHER;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_PK_GATHER: begin
        fab_rd_idx = node_q[IW-1:0];
        // Slots beyond the last node stay zero when N is not a multiple of 8.
        if (node_q < N_L) begin
          data_d[4*slot_q +: 4] = 4'(fab_rd_dir);
          node_d = node_q + (IW+1)'(1);
        end
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) state_d = S_PK_WRITE;
      end
      S_PK_WRITE: begin
        if (txn_rdy) begin
          if (node_q == N_L) begin
            run_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            word_d  = word_q + (IW+1)'(1);
            slot_d  = '0;
            data_d  = '0;
            state_d = S_PK_GATHER;
          end
        end
      end
      S_DONE: begin
        int_done = ie_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An abort waits for an in-flight bus transfer to be accepted before dropping to idle.
    if (abort_q || abort_now) begin
      if (req_now && !txn_rdy) begin
        abort_d = 1'b1;
      end else begin
        abort_d = 1'b0;
        state_d = S_IDLE;
        run_d   = 1'b0;
        load_d  = 1'b0;
        done_d  = done_q;
      end
    end
  end

endmodule

// File: tb/tb_fabric_ctrl.sv
// Directed bench for fabric_ctrl at DIM=4, WW=4: load, stall, run/settle, pack, abort and
// asynchronous reset, with hand-computed bus addresses, packed words and control readback.
module tb_fabric_ctrl;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          ctrl_wr = 1'b0;
  logic [31:0]   ctrl_in = '0;
  logic [31:0]   ctrl_out;
  logic          txn_req, txn_wr;
  logic [31:0]   txn_addr, txn_wdata;
  logic          txn_rdy = 1'b0;
  logic [31:0]   txn_rdata = '0;
  logic          fab_rst, fab_ld, fab_src_vld, int_done;
  logic [IW-1:0] fab_ld_idx, fab_src_idx, fab_rd_idx;
  logic [3:0]    fab_ld_weight;
  logic          fab_activity = 1'b0;
  logic [2:0]    fab_rd_dir;

  always #5 clk = ~clk;

  fabric_ctrl #(
    .DIM(4), .WW(4), .DW(3),
    .ADDR_MAP(32'h40000000), .ADDR_DIR(32'h40002000), .SETTLE(16)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .ctrl_wr(ctrl_wr), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out),
    .txn_req(txn_req), .txn_wr(txn_wr), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
    .txn_rdy(txn_rdy), .txn_rdata(txn_rdata),
    .fab_rst(fab_rst), .fab_ld(fab_ld), .fab_ld_idx(fab_ld_idx), .fab_ld_weight(fab_ld_weight),
    .fab_src_vld(fab_src_vld), .fab_src_idx(fab_src_idx), .fab_activity(fab_activity),
    .fab_rd_idx(fab_rd_idx), .fab_rd_dir(fab_rd_dir), .int_done(int_done)
  );

  // Fabric model: direction of node i is i mod 8.
  assign fab_rd_dir = fab_rd_idx[2:0];

  int n_cmp = 0;
  int n_bad = 0;
  int ld_cnt = 0;
  int rst_cnt = 0;
  int irq_cnt = 0;
  logic [3:0] ld_w [16];

  always @(negedge clk) begin
    if (fab_ld) begin
      ld_cnt++;
      ld_w[fab_ld_idx] = fab_ld_weight;
    end
    if (fab_rst)  rst_cnt++;
    if (int_done) irq_cnt++;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    ctrl_in = v;
    ctrl_wr = 1'b1;
    tick;
    ctrl_wr = 1'b0;
    ctrl_in = '0;
  endtask

  // Waits for a request, stalls it, then accepts it; reports how long it was held stable.
  task automatic serve(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [31:0] rdata, input int stall,
                       output logic [31:0] wdata, output int held, output int ld_seen);
    int n;
    n = 0;
    held = 0;
    wdata = '0;
    ld_seen = ld_cnt;
    while (!txn_req && n < 200) begin
      tick;
      n++;
    end
    if (!txn_req) begin
      check_val({tag, "_req_timeout"}, 32'(txn_req), 32'd1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      if (txn_req && txn_addr == exp_addr && txn_wr == exp_wr) held++;
      tick;
    end
    check_val({tag, "_addr"}, txn_addr, exp_addr);
    check_val({tag, "_wr"}, 32'(txn_wr), 32'(exp_wr));
    if (txn_req) held++;
    ld_seen = ld_cnt;
    wdata = txn_wdata;
    txn_rdy = 1'b1;
    txn_rdata = rdata;
    tick;
    txn_rdy = 1'b0;
    txn_rdata = '0;
    check_val({tag, "_req_drop"}, 32'(txn_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    int held, ldb, n, base, reqs;

    tick;
    tick;
    check_val("rst_ctrl_out", ctrl_out, 32'h0);
    check_val("rst_req", 32'(txn_req), 32'd0);
    check_val("rst_addr", txn_addr, 32'h0);
    check_val("rst_outs", {27'd0, fab_ld, fab_rst, fab_src_vld, int_done, txn_wr}, 32'h0);
    arst_n = 1'b1;
    tick;

    // Load with a 5-cycle stall on the first read.
    ctrl_write(32'h40000000);
    serve("ld0", 1'b0, 32'h40000000, 32'h76543210, 5, wd, held, ldb);
    check_val("ld0_held", 32'(held), 32'd6);
    check_val("ld0_no_strobe", 32'(ldb), 32'd0);
    serve("ld1", 1'b0, 32'h40000004, 32'hFEDCBA98, 0, wd, held, ldb);
    reqs = 0;
    for (int i = 0; i < 16; i++) begin
      if (txn_req) reqs++;
      tick;
    end
    check_val("ld_extra_reads", 32'(reqs), 32'd0);
    check_val("ld_count", 32'(ld_cnt), 32'd16);
    for (int i = 0; i < 16; i++) check_val($sformatf("ld_w%0d", i), 32'(ld_w[i]), 32'(i));
    check_val("ld_ctrl_out", ctrl_out, 32'h0);

    // Run from (x=2, y=1) with interrupt enabled.
    fab_activity = 1'b1;
    ctrl_write(32'h90000022);
    n = 0;
    while (!fab_src_vld && n < 50) begin
      tick;
      n++;
    end
    check_val("run_src_vld", 32'(fab_src_vld), 32'd1);
    check_val("run_src_idx", 32'(fab_src_idx), 32'd6);
    repeat (10) tick;
    fab_activity = 1'b0;
    n = 0;
    while (fab_src_vld && n < 100) begin
      tick;
      n++;
    end
    check_val("settle_cycles", 32'(n), 32'd16);
    check_val("fab_rst_pulses", 32'(rst_cnt), 32'd1);
    serve("pk0", 1'b1, 32'h40002000, 32'h0, 0, wd, held, ldb);
    check_val("pk0_data", wd, 32'h76543210);
    serve("pk1", 1'b1, 32'h40002004, 32'h0, 2, wd, held, ldb);
    check_val("pk1_data", wd, 32'h76543210);
    check_val("pk1_held", 32'(held), 32'd3);
    repeat (4) tick;
    check_val("irq_pulses", 32'(irq_cnt), 32'd1);
    check_val("done_ctrl_out", ctrl_out, 32'h30000022);

    // Rerun (clearing done), then abort during a stalled pack write.
    ctrl_write(32'hB0000022);
    check_val("w1c_done", ctrl_out, 32'h90000022);
    n = 0;
    while (!txn_req && n < 200) begin
      tick;
      n++;
    end
    check_val("ab_req_seen", 32'(txn_req), 32'd1);
    base = irq_cnt;
    tick;
    ctrl_write(32'h0);
    check_val("ab_req_held", 32'(txn_req), 32'd1);
    check_val("ab_addr_held", txn_addr, 32'h40002000);
    tick;
    txn_rdy = 1'b1;
    tick;
    txn_rdy = 1'b0;
    check_val("ab_req_drop", 32'(txn_req), 32'd0);
    reqs = 0;
    for (int i = 0; i < 30; i++) begin
      if (txn_req) reqs++;
      tick;
    end
    check_val("ab_no_more_req", 32'(reqs), 32'd0);
    check_val("ab_ctrl_out", ctrl_out, 32'h10000022);
    check_val("ab_no_irq", 32'(irq_cnt), 32'(base));

    // Asynchronous reset in the middle of unpacking, then a clean reload.
    ctrl_write(32'h40000000);
    serve("rl0", 1'b0, 32'h40000000, 32'hFEDCBA98, 0, wd, held, ldb);
    tick;
    tick;
    #1 arst_n = 1'b0;
    #1;
    check_val("arst_fab_ld", 32'(fab_ld), 32'd0);
    check_val("arst_ctrl_out", ctrl_out, 32'h0);
    check_val("arst_req", 32'(txn_req), 32'd0);
    tick;
    arst_n = 1'b1;
    tick;
    base = ld_cnt;
    ctrl_write(32'h40000000);
    serve("rl1", 1'b0, 32'h40000000, 32'hFEDCBA98, 0, wd, held, ldb);
    serve("rl2", 1'b0, 32'h40000004, 32'h76543210, 0, wd, held, ldb);
    repeat (12) tick;
    check_val("rl_count", 32'(ld_cnt - base), 32'd16);
    for (int i = 0; i < 16; i++) check_val($sformatf("rl_w%0d", i), 32'(ld_w[i]), 32'((i + 8) % 16));
    check_val("rl_ctrl_out", ctrl_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fabric_ctrl.md
Name: fabric_ctrl

Overview:
- Parametrised controller for the shortest-path node fabric, with configurable grid side, weight width and settle window.
- Sequence: bulk-loads packed node weights from memory, seeds a start node, runs the fabric until activity settles, then packs per-node direction codes back to memory.
- Raises a done interrupt at the end. Sits between the control-register/bus master port and the node array.

Parameters:
- DIM, 32, grid side; power of two, 2..32. N = DIM*DIM nodes. CW = clog2(DIM). IW = clog2(N).
- WW, 4, weight bits per node; one of 1, 2, 4, 8. WPW = 32/WW weights per word.
- DW, 3, direction code width, ≤4. Each direction occupies a 4-bit slot, 8 per word, slot k at bits [4k+3:4k], zero-padded.
- ADDR_MAP, 32'h40000000, byte base of the weight map.
- ADDR_DIR, 32'h40002000, byte base of the direction output.
- SETTLE, 16, consecutive idle cycles that declare convergence; ≥2.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- ctrl_wr  in  1  control register write strobe
- ctrl_in  in  32  [31] run, [30] load, [29] done (write 1 clears), [28] ie, [9:5] start_y, [4:0] start_x
- ctrl_out  out  32  {run, load, done, ie, 18'd0, start_y, start_x}
- txn_req  out  1  bus request; held until accepted
- txn_wr  out  1  1 = write
- txn_addr  out  32  byte address
- txn_wdata  out  32  write data
- txn_rdy  in  1  accept/complete in the same cycle
- txn_rdata  in  32  read data, valid when txn_rdy=1 on a read
- fab_rst  out  1  one-cycle fabric reset of costs/dirs
- fab_ld  out  1  weight load strobe
- fab_ld_idx  out  IW  node index for the load
- fab_ld_weight  out  WW  weight for the load
- fab_src_vld  out  1  start node clamp active
- fab_src_idx  out  IW  start index = start_y*DIM + start_x
- fab_activity  in  1  OR of node modify flags
- fab_rd_idx  out  IW  direction read index
- fab_rd_dir  in  DW  combinational direction of node fab_rd_idx
- int_done  out  1  one-cycle done pulse

Behaviour:
- Reset: every output 0; all registers 0; state IDLE. ctrl_out = 0.
- Coordinates: start_x and start_y use their low CW bits only; upper bits are stored and read back unchanged.
- Ctrl writes in IDLE/DONE: all fields load; done clears if bit 29 = 1.
- Ctrl writes while busy: only abort is honoured (run=0 and load=0). Other fields are ignored.
- Abort: if txn_req is high, the current transfer completes first. Then go to IDLE with run=load=0. done is not set and no interrupt fires.
- Bus handshake: req/addr/wr/wdata stay stable from assertion until the cycle txn_rdy=1. req drops the next cycle. One transaction outstanding at a time. txn_rdy while req=0 is ignored.
- IDLE: load=1 -> LD_REQ with word=0, node=0. Else run=1 -> RUN_INIT. Load has priority; if both are set, the run follows the load.
- LD_REQ: read at ADDR_MAP + 4*word. On rdy, capture the word and go to LD_UNPACK.
- LD_UNPACK: WPW cycles. Each cycle: fab_ld=1, fab_ld_idx=node, fab_ld_weight = slot (node mod WPW) at bits [WW*k+WW-1:WW*k]; node++.
- After LD_UNPACK: if node wraps to N, clear load and go to IDLE; else word++ and return to LD_REQ. Total reads = N/WPW; with WPW > N, one read and only N strobes.
- RUN_INIT: fab_rst=1 for one cycle; settle counter = SETTLE. Go to RUN.
- RUN: fab_src_vld=1 (it is also 1 in RUN_INIT). Counter reloads to SETTLE when fab_activity=1, otherwise decrements. Reaching 0 -> PK_GATHER with node=0, word=0.
- RUN with the fabric permanently active: no timeout; stays in RUN until aborted.
- PK_GATHER: 8 cycles. fab_rd_idx=node; capture fab_rd_dir into slot (node mod 8); node++. For N < 8 the unused slots are 0. Then go to PK_WRITE.
- PK_WRITE: write the packed word to ADDR_DIR + 4*word. On rdy: if all N nodes are packed, go to DONE; else word++ and return to PK_GATHER.
- DONE: run=0, done=1. int_done=1 for one cycle if ie=1. Go to IDLE the next cycle.
- Address arithmetic: 32-bit, wraps modulo 2^32.

Test Plan:
- DIM=4, WW=4: load=1; reads return 32'h76543210 then 32'hFEDCBA98 -> exactly 2 reads (addr 40000000, 40000004); 16 fab_ld strobes; idx i gets weight i; load bit clears.
- Bus stall: hold txn_rdy=0 for 5 cycles on the first read -> req/addr stable for 6 cycles; no fab_ld until the rdy cycle.
- run=1, start (x=2, y=1), ie=1; fab_activity high 10 cycles then low -> fab_src_idx=6; PK_GATHER begins SETTLE=16 cycles after the last activity.
- Pack with fab_rd_dir = idx mod 8 -> writes 32'h76543210 to 40002000 and 40002004; then done=1 and a single int_done pulse.
- Abort during a stalled pack write (rdy low) -> write completes on rdy; then IDLE; done=0; no int_done.
- arst_n low mid-LD_UNPACK -> all outputs 0 immediately; ctrl_out=0; the next load restarts at word 0.
